pc_sequencer: RTL and testbench

Parametrised program-counter unit for the CPU fetch stage. It replaces the plain load-only PC with an on-chip op decoder that supports hold, increment, absolute jump, PC-relative branch, call and return. Calls and returns use a small internal return-address stack (RAS). The PC is a registered output that drives instruction-memory address generation. The control unit issues exactly one op per enabled cycle.

---
 rtl/pc_pkg.sv | 13 +
 rtl/ras_stack.sv | 56 +++++
 rtl/pc_sequencer.sv | 95 +++++++++
 tb/tb_pc_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: op encoding and width.
package pc_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD = 3'd0;
    localparam logic [OP_W-1:0] OP_INC  = 3'd1;
    localparam logic [OP_W-1:0] OP_JMP  = 3'd2;
    localparam logic [OP_W-1:0] OP_BR   = 3'd3;
    localparam logic [OP_W-1:0] OP_CALL = 3'd4;
    localparam logic [OP_W-1:0] OP_RET  = 3'd5;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push-when-full overwrites the oldest entry,
// pop-when-empty is a no-op; both are flagged combinationally for the caller.
module ras_stack #(
    parameter int PC_W      = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            overflow,
    output logic            underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [CNT_W-1:0] cnt;

    assign ptr_inc   = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    assign ptr_dec   = (ptr == '0) ? PTR_LAST : ptr - 1'b1;
    assign empty     = (cnt == '0);
    assign full      = (cnt == CNT_MAX);
    assign overflow  = push && full;
    assign underflow = pop && empty;
    assign top       = mem[ptr];

    // ptr always names the most recent entry; a full push wraps onto the oldest
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr_inc;
            if (!full) cnt <= cnt + 1'b1;
        end else if (pop && !empty) begin
            ptr <= ptr_dec;
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) mem[ptr_inc] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: decodes hold/inc/jump/branch/call/return ops
// and keeps return addresses in an internal circular stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter int unsigned     INC       = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [OP_W-1:0] op,
    input  logic [PC_W-1:0] target,
    input  logic [PC_W-1:0] offset,
    output logic [PC_W-1:0] pc,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            err
);

    localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

    logic signed [PC_W-1:0] offset_s;
    logic [PC_W-1:0]        pc_ret;
    logic [PC_W-1:0]        ras_top;
    logic                   push;
    logic                   pop;
    logic                   ras_ovf;
    logic                   ras_unf;
    logic [PC_W-1:0]        pc_p0;
    logic                   err_p0;

    function automatic logic [PC_W-1:0] wrap_add(input logic [PC_W-1:0] a,
                                                 input logic signed [PC_W-1:0] b);
        return a + b;
    endfunction

    assign offset_s = offset;
    assign pc_ret   = wrap_add(pc, INC_V);
    assign push     = en && (op == OP_CALL);
    assign pop      = en && (op == OP_RET);

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .din       (pc_ret),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_ovf),
        .underflow (ras_unf)
    );

    // Stage p0: op decode and next-PC select
    always_comb begin
        pc_p0  = pc;
        err_p0 = 1'b0;
        if (en) begin
            case (op)
                OP_HOLD: pc_p0 = pc;
                OP_INC:  pc_p0 = pc_ret;
                OP_JMP:  pc_p0 = target;
                OP_BR:   pc_p0 = wrap_add(pc, offset_s);
                OP_CALL: begin
                    pc_p0  = target;
                    err_p0 = ras_ovf;
                end
                OP_RET: begin
                    if (ras_unf) err_p0 = 1'b1;
                    else         pc_p0  = ras_top;
                end
                default: err_p0 = 1'b1;
            endcase
        end
    end

    // Stage p1: registered pc and single-cycle error pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc  <= RESET_VEC;
            err <= 1'b0;
        end else begin
            if (en) pc <= pc_p0;
            err <= err_p0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a reference model queues expected outputs
// per step, which are popped and compared one cycle later.
module tb_pc_sequencer;

    localparam int          PC_W      = 16;
    localparam int          RAS_DEPTH = 4;
    localparam logic [15:0] RESET_VEC = 16'h0000;
    localparam logic [15:0] INC_V     = 16'h0001;

    localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, JMP = 3'd2, BR = 3'd3,
                           CALL = 3'd4, RET = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] target = 16'h0;
    logic [15:0] offset = 16'h0;
    logic [15:0] pc;
    logic        ras_empty;
    logic        ras_full;
    logic        err;

    typedef struct packed {
        logic [15:0] pc;
        logic        empty;
        logic        full;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_pc = RESET_VEC;
    logic [15:0] m_ras[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH),
        .RESET_VEC (RESET_VEC),
        .INC       (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .op        (op),
        .target    (target),
        .offset    (offset),
        .pc        (pc),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, predict the outcome with a bounded-queue stack model,
    // then compare after the edge.
    task automatic step(input string tag, input logic r, input logic e, input logic [2:0] o,
                        input logic [15:0] t, input logic [15:0] ofs);
        exp_t x;
        logic merr;
        merr = 1'b0;
        @(negedge clk);
        reset = r; en = e; op = o; target = t; offset = ofs;
        if (!r) begin
            m_pc = RESET_VEC;
            m_ras.delete();
        end else if (e) begin
            case (o)
                INC: m_pc = m_pc + INC_V;
                JMP: m_pc = t;
                BR:  m_pc = m_pc + ofs;
                CALL: begin
                    if (m_ras.size() == RAS_DEPTH) begin
                        void'(m_ras.pop_front());
                        merr = 1'b1;
                    end
                    m_ras.push_back(m_pc + INC_V);
                    m_pc = t;
                end
                RET: begin
                    if (m_ras.size() == 0) merr = 1'b1;
                    else                   m_pc = m_ras.pop_back();
                end
                3'd6, 3'd7: merr = 1'b1;
                default: ;
            endcase
        end
        x.pc    = m_pc;
        x.empty = (m_ras.size() == 0);
        x.full  = (m_ras.size() == RAS_DEPTH);
        x.err   = merr;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({tag, ".pc"}, 32'(pc), 32'(x.pc));
        chk({tag, ".empty"}, 32'(ras_empty), 32'(x.empty));
        chk({tag, ".full"}, 32'(ras_full), 32'(x.full));
        chk({tag, ".err"}, 32'(err), 32'(x.err));
    endtask

    initial begin
        // reset
        step("reset", 1'b0, 1'b0, HOLD, 16'h0, 16'h0);
        chk("reset_pc", 32'(pc), 32'h0000);
        chk("reset_empty", 32'(ras_empty), 32'h1);

        // increment
        step("inc1", 1'b1, 1'b1, INC, 16'h0, 16'h0);
        step("inc2", 1'b1, 1'b1, INC, 16'h0, 16'h0);
        step("inc3", 1'b1, 1'b1, INC, 16'h0, 16'h0);
        chk("inc3_pc", 32'(pc), 32'h0003);

        // branch backward and wrap-around
        step("br_back", 1'b1, 1'b1, BR, 16'h0, 16'hFFFE);
        chk("br_back_pc", 32'(pc), 32'h0001);
        step("jmp_top", 1'b1, 1'b1, JMP, 16'hFFFF, 16'h0);
        step("inc_wrap", 1'b1, 1'b1, INC, 16'h0, 16'h0);
        chk("inc_wrap_pc", 32'(pc), 32'h0000);
        step("br_fwd_wrap", 1'b1, 1'b1, BR, 16'h0, 16'h0005);
        step("br_neg_wrap", 1'b1, 1'b1, BR, 16'h0, 16'hFFF0);

        // single call / return
        step("jmp10", 1'b1, 1'b1, JMP, 16'h0010, 16'h0);
        step("call1", 1'b1, 1'b1, CALL, 16'h0100, 16'h0);
        chk("call1_pc", 32'(pc), 32'h0100);
        step("ret1", 1'b1, 1'b1, RET, 16'h0, 16'h0);
        chk("ret1_pc", 32'(pc), 32'h0011);
        chk("ret1_empty", 32'(ras_empty), 32'h1);

        // overflow and underflow
        step("jmp10b", 1'b1, 1'b1, JMP, 16'h0010, 16'h0);
        step("callA", 1'b1, 1'b1, CALL, 16'h0020, 16'h0);
        step("callB", 1'b1, 1'b1, CALL, 16'h0030, 16'h0);
        step("callC", 1'b1, 1'b1, CALL, 16'h0040, 16'h0);
        step("callD", 1'b1, 1'b1, CALL, 16'h0050, 16'h0);
        chk("callD_full", 32'(ras_full), 32'h1);
        step("callE", 1'b1, 1'b1, CALL, 16'h0060, 16'h0);
        chk("callE_err", 32'(err), 32'h1);
        step("retA", 1'b1, 1'b1, RET, 16'h0, 16'h0);
        chk("retA_pc", 32'(pc), 32'h0051);
        step("retB", 1'b1, 1'b1, RET, 16'h0, 16'h0);
        step("retC", 1'b1, 1'b1, RET, 16'h0, 16'h0);
        step("retD", 1'b1, 1'b1, RET, 16'h0, 16'h0);
        chk("retD_pc", 32'(pc), 32'h0021);
        step("retE", 1'b1, 1'b1, RET, 16'h0, 16'h0);
        chk("retE_pc", 32'(pc), 32'h0021);
        chk("retE_err", 32'(err), 32'h1);
        step("after_err", 1'b1, 1'b1, HOLD, 16'h0, 16'h0);

        // enable gating
        step("gate1", 1'b1, 1'b0, JMP, 16'h1234, 16'h0);
        step("gate2", 1'b1, 1'b0, JMP, 16'h1234, 16'h0);
        step("gate3", 1'b1, 1'b0, RET, 16'h1234, 16'h0);
        chk("gate_pc", 32'(pc), 32'h0021);

        // mid-operation reset
        step("callR1", 1'b1, 1'b1, CALL, 16'h0200, 16'h0);
        step("callR2", 1'b1, 1'b1, CALL, 16'h0300, 16'h0);
        step("rst_mid", 1'b0, 1'b1, CALL, 16'h0400, 16'h0);
        chk("rst_mid_pc", 32'(pc), 32'(RESET_VEC));
        step("post_rst", 1'b1, 1'b1, HOLD, 16'h0, 16'h0);

        // reserved ops, with one return address on the stack
        step("jmp41", 1'b1, 1'b1, JMP, 16'h0041, 16'h0);
        step("call_self", 1'b1, 1'b1, CALL, 16'h0042, 16'h0);
        step("rsv6", 1'b1, 1'b1, 3'd6, 16'h0777, 16'h0003);
        chk("rsv6_pc", 32'(pc), 32'h0042);
        chk("rsv6_err", 32'(err), 32'h1);
        step("rsv_clear", 1'b1, 1'b1, HOLD, 16'h0, 16'h0);
        step("rsv7", 1'b1, 1'b1, 3'd7, 16'h0777, 16'h0);
        step("ret_self", 1'b1, 1'b1, RET, 16'h0, 16'h0);
        chk("ret_self_pc", 32'(pc), 32'h0042);
        step("final", 1'b1, 1'b1, INC, 16'h0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
